// File: rtl/delay_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// delay_buffer_ctrl
// Sequencer for a RAM-backed variable-delay buffer. A stream of L samples, one
// per cycle, is written to a circular RAM and read back D cycles later. The RAM
// beside this block is 1R/1W, depth 2^ADDR_W, with a 1-cycle read latency.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   run             start pulse, honoured only while idle
//   cfg_delay       delay D in cycles (0 is clamped to 1)
//   cfg_length      number of samples L
//   busy            high from the cycle after an accepted run to the done cycle
//   wr_en, wr_addr  RAM write strobe / circular write address
//   rd_en, rd_addr  RAM read strobe / circular read address
//   out_valid       RAM read data valid (rd_en delayed one cycle)
//   done            one-cycle completion pulse, coincident with last out_valid
//   delay_clamped   sticky: a run was accepted with cfg_delay = 0
// -----------------------------------------------------------------------------
module delay_buffer_ctrl #(
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] cfg_delay,
  input  logic [LEN_W-1:0]  cfg_length,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  output logic              done,
  output logic              delay_clamped
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t            r_state,    w_state_nxt;
  logic [ADDR_W-1:0] r_delay,    w_delay_nxt;
  logic [LEN_W-1:0]  r_length,   w_length_nxt;
  logic [LEN_W-1:0]  r_wr_cnt,   w_wr_cnt_nxt;
  logic [LEN_W-1:0]  r_rd_cnt,   w_rd_cnt_nxt;
  logic [LEN_W-1:0]  r_cyc_cnt,  w_cyc_cnt_nxt;
  logic [ADDR_W-1:0] r_wr_addr,  w_wr_addr_nxt;
  logic [ADDR_W-1:0] r_rd_addr,  w_rd_addr_nxt;
  logic              r_wr_en,    w_wr_en_nxt;
  logic              r_rd_en,    w_rd_en_nxt;
  logic              r_clamped,  w_clamped_nxt;
  logic              r_busy;
  logic              r_done;
  logic              r_out_valid;

  // Next-state logic. Every output is a flop, so this block computes what the
  // strobes and pointers must be in the *next* cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_delay_nxt   = r_delay;
    w_length_nxt  = r_length;
    w_wr_cnt_nxt  = r_wr_cnt;
    w_rd_cnt_nxt  = r_rd_cnt;
    w_cyc_cnt_nxt = r_cyc_cnt;
    w_wr_addr_nxt = r_wr_addr;
    w_rd_addr_nxt = r_rd_addr;
    w_clamped_nxt = r_clamped;
    w_wr_en_nxt   = 1'b0;
    w_rd_en_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          if (cfg_delay == '0) begin
            w_delay_nxt   = ADDR_W'(1);
            w_clamped_nxt = 1'b1;
          end else begin
            w_delay_nxt   = cfg_delay;
          end
          w_length_nxt  = cfg_length;
          w_wr_cnt_nxt  = '0;
          w_rd_cnt_nxt  = '0;
          w_cyc_cnt_nxt = '0;
          w_wr_addr_nxt = '0;
          w_rd_addr_nxt = '0;
          // Writes begin the very next cycle; an empty transfer only flushes.
          w_wr_en_nxt   = (cfg_length != '0);
          w_state_nxt   = (cfg_length == '0) ? S_FLUSH : S_RUN;
        end
      end

      S_RUN: begin
        // r_cyc_cnt is the number of RUN cycles already elapsed.
        w_cyc_cnt_nxt = r_cyc_cnt + LEN_W'(1);
        if (r_wr_en) begin
          w_wr_cnt_nxt  = r_wr_cnt + LEN_W'(1);
          w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
        end
        if (r_rd_en) begin
          w_rd_cnt_nxt  = r_rd_cnt + LEN_W'(1);
          w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
        end
        w_wr_en_nxt = (w_wr_cnt_nxt < r_length);
        // Reads form one contiguous burst: it starts exactly D cycles after the
        // first write and then continues until L reads are issued. The cycle
        // match happens long before r_cyc_cnt could wrap, and termination is
        // decided on rd_cnt alone.
        if (r_rd_en) begin
          w_rd_en_nxt = (w_rd_cnt_nxt < r_length);
        end else begin
          w_rd_en_nxt = (r_rd_cnt == '0) && (w_cyc_cnt_nxt == LEN_W'(r_delay));
        end
        if (r_rd_en && (w_rd_cnt_nxt == r_length)) begin
          w_state_nxt = S_FLUSH;
        end
      end

      S_FLUSH: w_state_nxt = S_IDLE;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_delay     <= '0;
      r_length    <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_cyc_cnt   <= '0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_clamped   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // r_out_valid below relies on seeing the old r_rd_en.
      r_state     <= w_state_nxt;
      r_delay     <= w_delay_nxt;
      r_length    <= w_length_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_cyc_cnt   <= w_cyc_cnt_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_clamped   <= w_clamped_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      // FLUSH lasts one cycle, so entering it is the completion pulse.
      r_done      <= (w_state_nxt == S_FLUSH);
      // Matches the RAM's one-cycle read latency.
      r_out_valid <= r_rd_en;
    end
  end

  assign busy          = r_busy;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign rd_en         = r_rd_en;
  assign rd_addr       = r_rd_addr;
  assign out_valid     = r_out_valid;
  assign done          = r_done;
  assign delay_clamped = r_clamped;

endmodule

// File: tb/tb_delay_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_delay_buffer_ctrl
// Scoreboard bench: each start() pushes the hand-derived strobe schedule (cycle
// and address) into queues; an independent monitor pops and compares every
// time the DUT raises a strobe or changes busy.
// Cycle numbering: run is driven during cycle T; the DUT responds in T+1.
// -----------------------------------------------------------------------------
module tb_delay_buffer_ctrl;

  localparam int ADDR_W = 6;
  localparam int LEN_W  = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic [ADDR_W-1:0] cfg_delay;
  logic [LEN_W-1:0]  cfg_length;
  logic              busy, wr_en, rd_en, out_valid, done, delay_clamped;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  delay_buffer_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .cfg_delay     (cfg_delay),
    .cfg_length    (cfg_length),
    .busy          (busy),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .out_valid     (out_valid),
    .done          (done),
    .delay_clamped (delay_clamped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t q_wr[$];
  ev_t q_rd[$];
  ev_t q_ov[$];
  ev_t q_done[$];
  ev_t q_busy[$];

  int n_cmp = 0;
  int n_err = 0;
  int cur_d = 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pending();
    return q_wr.size() + q_rd.size() + q_ov.size() + q_done.size() + q_busy.size();
  endfunction

  // Monitor: compares whatever the DUT presents against the scoreboard.
  logic              prev_busy = 1'b0;
  logic [ADDR_W-1:0] gap;
  always @(negedge clk) begin
    ev_t e;
    if (wr_en) begin
      check("wr_expected", int'(q_wr.size() > 0), 1);
      if (q_wr.size() > 0) begin
        e = q_wr.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_addr", int'(wr_addr), e.val);
      end
    end
    if (rd_en) begin
      check("rd_expected", int'(q_rd.size() > 0), 1);
      if (q_rd.size() > 0) begin
        e = q_rd.pop_front();
        check("rd_cycle", cyc, e.cyc);
        check("rd_addr", int'(rd_addr), e.val);
      end
    end
    if (wr_en && rd_en) begin
      gap = wr_addr - rd_addr;
      check("addr_gap", int'(gap), cur_d);
    end
    if (out_valid) begin
      check("ov_expected", int'(q_ov.size() > 0), 1);
      if (q_ov.size() > 0) begin
        e = q_ov.pop_front();
        check("ov_cycle", cyc, e.cyc);
      end
    end
    if (done) begin
      check("done_expected", int'(q_done.size() > 0), 1);
      if (q_done.size() > 0) begin
        e = q_done.pop_front();
        check("done_cycle", cyc, e.cyc);
      end
    end
    if (busy != prev_busy) begin
      check("busy_edge_expected", int'(q_busy.size() > 0), 1);
      if (q_busy.size() > 0) begin
        e = q_busy.pop_front();
        check("busy_edge_cycle", cyc, e.cyc);
        check("busy_level", int'(busy), e.val);
      end
    end
    prev_busy = busy;
  end

  // Issue a run and push its expected schedule. D=0 behaves as D=1; L=0
  // produces only a done pulse in T+1.
  task automatic start(input int d, input int l, output int t);
    int de, t_done;
    @(negedge clk);
    t          = cyc;
    cfg_delay  = ADDR_W'(d);
    cfg_length = LEN_W'(l);
    run        = 1'b1;
    de         = (d == 0) ? 1 : d;
    cur_d      = de;
    t_done     = (l == 0) ? t + 1 : t + de + l + 1;
    for (int i = 0; i < l; i++) begin
      q_wr.push_back('{t + 1 + i, i % DEPTH});
      q_rd.push_back('{t + 1 + de + i, i % DEPTH});
      q_ov.push_back('{t + 2 + de + i, 0});
    end
    q_done.push_back('{t_done, 0});
    q_busy.push_back('{t + 1, 1});
    q_busy.push_back('{t_done + 1, 0});
    @(negedge clk);
    run = 1'b0;
  endtask

  // A run pulse that must be ignored: no expectations are pushed.
  task automatic ignored_run(input int d, input int l);
    cfg_delay  = ADDR_W'(d);
    cfg_length = LEN_W'(l);
    run        = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pending() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", int'(n < 400), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t;
    rst        = 1'b1;
    run        = 1'b0;
    cfg_delay  = '0;
    cfg_length = '0;

    // Reset state.
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_clamped", int'(delay_clamped), 0);
    check("rst_addrs", int'(wr_addr) + int'(rd_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    while (cyc < 9) @(negedge clk);

    // D=3, L=4, run at T=10.
    start(3, 4, t);
    wait_idle();

    // D=5, L=2: write burst, idle gap, read burst.
    start(5, 2, t);
    wait_idle();

    // D=63, L=130: both pointers wrap twice.
    start(63, 130, t);
    wait_idle();

    // cfg_delay=0 is clamped to 1 and latches the sticky flag.
    check("clamped_before", int'(delay_clamped), 0);
    start(0, 2, t);
    wait_idle();
    check("clamped_set", int'(delay_clamped), 1);
    start(4, 3, t);
    wait_idle();
    check("clamped_sticky", int'(delay_clamped), 1);

    // L=0: done in T+1 only; a run in that done cycle is ignored.
    start(7, 0, t);
    ignored_run(3, 5);
    wait_idle();

    // run during a busy window is ignored.
    start(2, 5, t);
    repeat (2) @(negedge clk);
    ignored_run(9, 9);
    wait_idle();

    // Asynchronous reset mid-RUN at T+5: outputs drop at once, no done.
    start(4, 8, t);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < t + 5);
    #1;
    rst = 1'b1;
    q_wr.delete();
    q_rd.delete();
    q_ov.delete();
    q_done.delete();
    q_busy.delete();
    q_busy.push_back('{t + 5, 0});
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_wr_en", int'(wr_en), 0);
    check("abort_rd_en", int'(rd_en), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_done", int'(done), 0);
    check("abort_clamped", int'(delay_clamped), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fresh run after the abort restarts with addresses at 0.
    start(2, 3, t);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
